code_entry_checker: RTL and testbench

- Keypad front end for the combination lock. Collects digits into a CODE_LEN-digit entry buffer and compares the entry against the stored passcode.
- Emits a one-cycle correct-code pulse (LockPulse) or wrong-code pulse (AttemptIn) to the downstream attempts/LED stage.
- Obeys that stage's lockout output. Also supports reprogramming the passcode from inside the door.

---
 rtl/code_entry_checker.sv | 180 ++++++++++++++++++
 tb/tb_code_entry_checker.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/code_entry_checker.sv
// code_entry_checker
//   Keypad front end for the combination lock. Shifts accepted digits into an
//   entry buffer, compares a complete entry against the stored passcode and
//   reports the result as a one-cycle pulse. An inside-door programming mode
//   replaces the stored passcode with a freshly keyed one.
//
// Ports
//   clk5            system clock
//   reset           synchronous, active-high
//   key_valid_i     one-cycle key strobe from the debounced keypad decoder
//   key_digit_i     key code; 0-9 are digits, 10-15 are ignored
//   clear_key_i     one-cycle abort-entry strobe
//   blocked_i       lockout from the attempts stage; inhibits user entry
//   prog_en_i       inside-door programming enable (level)
//   code_ok_o       one-cycle pulse: entry matched the stored code
//   attempt_wrong_o one-cycle pulse: entry did not match
//   prog_done_o     one-cycle pulse: new passcode stored
//   digit_count_o   digits accepted in the current entry
//   entering_o      high while collecting digits (ENTRY or PROG)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for the first digit; timer and count held at 0
// ENTRY | collecting a user entry
// CHECK | one cycle: compare entry with stored code, pulse result
// PROG  | collecting a new passcode (prog_en held high)
// STORE | one cycle: commit new passcode, pulse prog_done

module code_entry_checker #(
  parameter int                    CODE_LEN       = 4,
  parameter int                    TIMEOUT_CYCLES = 25000000,
  parameter logic [CODE_LEN*4-1:0] SECRET         = 16'h1234
) (
  input  logic       clk5,
  input  logic       reset,
  input  logic       key_valid_i,
  input  logic [3:0] key_digit_i,
  input  logic       clear_key_i,
  input  logic       blocked_i,
  input  logic       prog_en_i,
  output logic       code_ok_o,
  output logic       attempt_wrong_o,
  output logic       prog_done_o,
  output logic [2:0] digit_count_o,
  output logic       entering_o
);

  localparam int BW = CODE_LEN * 4;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_DIGIT = 3'(CODE_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_CHECK = 3'd2,
    S_PROG  = 3'd3,
    S_STORE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   buffer_q, buffer_d;
  logic [BW-1:0]   stored_q, stored_d;
  logic [2:0]      count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            blocked_q;

  logic            key_acc;
  logic            blocked_rise;
  logic            timeout;
  logic [BW-1:0]   shifted;

  assign key_acc      = key_valid_i && (key_digit_i <= 4'd9);
  assign blocked_rise = blocked_i && !blocked_q;
  assign timeout      = (timer_q == TIMER_LAST);
  assign shifted      = {buffer_q[BW-5:0], key_digit_i};

  always_ff @(posedge clk5) begin
    if (reset) begin
      state_q   <= S_IDLE;
      buffer_q  <= '0;
      stored_q  <= SECRET;
      count_q   <= '0;
      timer_q   <= '0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buffer_q  <= buffer_d;
      stored_q  <= stored_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      blocked_q <= blocked_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    buffer_d = buffer_q;
    stored_d = stored_q;
    count_d  = count_q;
    timer_d  = timer_q;

    case (state_q)
      S_IDLE: begin
        count_d = '0;
        timer_d = '0;
        // Programming is allowed even while the attempts stage is locked out.
        if (key_acc && (prog_en_i || !blocked_i)) begin
          buffer_d = {{(BW-4){1'b0}}, key_digit_i};
          count_d  = 3'd1;
          state_d  = prog_en_i ? S_PROG : S_ENTRY;
        end
      end

      S_ENTRY, S_PROG: begin
        // Abort conditions take priority over a key in the same cycle;
        // timeout only applies when no key arrives.
        if (clear_key_i
            || ((state_q == S_ENTRY) && blocked_rise)
            || ((state_q == S_PROG) && !prog_en_i)) begin
          state_d  = S_IDLE;
          buffer_d = '0;
          count_d  = '0;
          timer_d  = '0;
        end else if (key_acc) begin
          buffer_d = shifted;
          timer_d  = '0;
          if (count_q != 3'(CODE_LEN)) count_d = count_q + 3'd1;
          if (count_q == LAST_DIGIT)
            state_d = (state_q == S_ENTRY) ? S_CHECK : S_STORE;
        end else if (timeout) begin
          state_d  = S_IDLE;
          buffer_d = '0;
          count_d  = '0;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_CHECK: begin
        state_d = S_IDLE;
        count_d = '0;
        timer_d = '0;
      end

      S_STORE: begin
        stored_d = buffer_q;
        state_d  = S_IDLE;
        count_d  = '0;
        timer_d  = '0;
      end

      default: begin
        state_d  = S_IDLE;
        buffer_d = '0;
        count_d  = '0;
        timer_d  = '0;
      end
    endcase
  end

  always_comb begin
    code_ok_o       = 1'b0;
    attempt_wrong_o = 1'b0;
    prog_done_o     = 1'b0;
    entering_o      = 1'b0;
    digit_count_o   = count_q;
    case (state_q)
      S_CHECK: begin
        code_ok_o       = (buffer_q == stored_q);
        attempt_wrong_o = (buffer_q != stored_q);
      end
      S_STORE:         prog_done_o = 1'b1;
      S_ENTRY, S_PROG: entering_o  = 1'b1;
      default:         ;
    endcase
  end

endmodule

// File: tb/tb_code_entry_checker.sv
module tb_code_entry_checker;

  logic       clk5 = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       clear_key;
  logic       blocked;
  logic       prog_en;
  logic       code_ok;
  logic       attempt_wrong;
  logic       prog_done;
  logic [2:0] digit_count;
  logic       entering;

  int checks = 0;
  int errors = 0;
  logic pulse_seen;

  code_entry_checker #(
    .CODE_LEN(4),
    .TIMEOUT_CYCLES(20),
    .SECRET(16'h1234)
  ) dut (
    .clk5(clk5),
    .reset(reset),
    .key_valid_i(key_valid),
    .key_digit_i(key_digit),
    .clear_key_i(clear_key),
    .blocked_i(blocked),
    .prog_en_i(prog_en),
    .code_ok_o(code_ok),
    .attempt_wrong_o(attempt_wrong),
    .prog_done_o(prog_done),
    .digit_count_o(digit_count),
    .entering_o(entering)
  );

  always #5 clk5 = ~clk5;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One key strobe; returns at the negedge after the accepting edge.
  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    @(negedge clk5);
    key_valid = 1'b0;
    key_digit = 4'h0;
  endtask

  task automatic press4(input logic [15:0] c);
    press(c[15:12]);
    press(c[11:8]);
    press(c[7:4]);
    press(c[3:0]);
  endtask

  // Outputs packed as {code_ok, attempt_wrong, prog_done, entering, digit_count}
  function automatic logic [7:0] outs();
    return {1'b0, code_ok, attempt_wrong, prog_done, entering, digit_count};
  endfunction

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_digit = 4'h0;
    clear_key = 1'b0; blocked = 1'b0; prog_en = 1'b0;
    repeat (3) @(negedge clk5);
    reset = 1'b0;
    chk("reset_outs", outs(), 8'h00);

    // Correct code with digit_count progression
    press(4'd1); chk("cnt1", outs(), 8'h09);
    press(4'd2); chk("cnt2", outs(), 8'h0A);
    press(4'd3); chk("cnt3", outs(), 8'h0B);
    press(4'd4);
    chk("ok_pulse", code_ok, 1'b1);
    chk("ok_no_wrong", attempt_wrong, 1'b0);
    press(4'd5);   // lands in the CHECK cycle and is dropped
    chk("ok_back_idle", outs(), 8'h00);

    // Three wrong attempts, three separate pulses
    for (int i = 0; i < 3; i++) begin
      press4(16'h1235);
      chk("wrong_pulse", {code_ok, attempt_wrong}, 2'b01);
      @(negedge clk5);
      chk("wrong_single", outs(), 8'h00);
    end

    // Blocked: key ignored in IDLE
    blocked = 1'b1;
    press(4'd1);
    chk("blocked_ignore", outs(), 8'h00);
    blocked = 1'b0;
    @(negedge clk5);

    // Blocked rising mid-entry aborts without a pulse
    press(4'd1);
    blocked = 1'b1;
    @(negedge clk5);
    chk("blocked_abort", outs(), 8'h00);
    blocked = 1'b0;
    @(negedge clk5);

    // Timeout after 20 idle cycles in ENTRY
    press(4'd1);
    press(4'd2);
    pulse_seen = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk5);
      if (code_ok || attempt_wrong) pulse_seen = 1'b1;
    end
    chk("timeout_edge_still_entering", outs(), 8'h0A);
    @(negedge clk5);
    if (code_ok || attempt_wrong) pulse_seen = 1'b1;
    chk("timeout_idle", outs(), 8'h00);
    chk("timeout_no_pulse", pulse_seen, 1'b0);
    press4(16'h1234);
    chk("after_timeout_ok", code_ok, 1'b1);
    @(negedge clk5);

    // clear_key wins over a coincident key
    press(4'd1);
    press(4'd2);
    clear_key = 1'b1;
    press(4'd3);
    clear_key = 1'b0;
    chk("clear_idle", outs(), 8'h00);
    press(4'hA);
    chk("nondigit_idle", outs(), 8'h00);
    press(4'd1);
    press(4'hC);
    chk("nondigit_entry", outs(), 8'h09);
    clear_key = 1'b1;
    @(negedge clk5);
    clear_key = 1'b0;

    // Programming a new code
    prog_en = 1'b1;
    press(4'd9); press(4'd8); press(4'd7);
    chk("prog_cnt3", outs(), 8'h0B);
    press(4'd6);
    chk("prog_done_pulse", {code_ok, attempt_wrong, prog_done}, 3'b001);
    @(negedge clk5);
    chk("prog_done_single", outs(), 8'h00);
    prog_en = 1'b0;
    press4(16'h1234);
    chk("old_code_wrong", {code_ok, attempt_wrong}, 2'b01);
    @(negedge clk5);
    press4(16'h9876);
    chk("new_code_ok", {code_ok, attempt_wrong}, 2'b10);
    @(negedge clk5);

    // Dropping prog_en mid-programming leaves the stored code alone
    prog_en = 1'b1;
    press(4'd5); press(4'd5);
    prog_en = 1'b0;
    @(negedge clk5);
    chk("prog_abort_idle", outs(), 8'h00);
    press4(16'h9876);
    chk("prog_abort_keeps", code_ok, 1'b1);
    @(negedge clk5);

    // Reset mid-entry restores SECRET
    press(4'd1); press(4'd2); press(4'd3);
    reset = 1'b1;
    @(negedge clk5);
    reset = 1'b0;
    chk("reset_mid_outs", outs(), 8'h00);
    press4(16'h1234);
    chk("reset_secret_ok", code_ok, 1'b1);
    @(negedge clk5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
